// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : PC holder and instruction fetch stage; one-cycle synchronous
//            instruction memory, valid/ready hand-off to the decoder.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int unsigned        ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] link_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_instr;
  logic              r_valid;
  logic [ADDR_W-1:0] r_pc_out;
  logic [15:0]       r_count;
  logic              w_handshake;

  assign w_handshake = (r_state == S_VALID) && instr_ready;

  assign mem_addr    = r_pc;
  assign mem_rd      = (r_state == S_REQ);
  assign instr_out   = r_instr;
  assign instr_valid = r_valid;
  assign pc_out      = r_pc_out;
  assign link_pc     = r_pc_out + 1'b1;
  assign fetch_count = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC;
      r_instr  <= 16'h0000;
      r_valid  <= 1'b0;
      r_pc_out <= '0;
      r_count  <= 16'h0000;
    end else if (redirect) begin
      // Redirect beats everything, but a handshake in the same cycle still counts.
      r_pc    <= redirect_pc;
      r_valid <= 1'b0;
      r_state <= S_REQ;
      if (w_handshake) begin
        r_count <= r_count + 16'd1;
      end
    end else begin
      case (r_state)
        S_REQ: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_instr  <= mem_rdata;
          r_pc_out <= r_pc;
          r_pc     <= r_pc + 1'b1;
          r_valid  <= 1'b1;
          r_state  <= S_VALID;
        end
        S_VALID: begin
          if (instr_ready) begin
            r_valid <= 1'b0;
            r_count <= r_count + 16'd1;
            r_state <= S_REQ;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_REQ;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed plus random stimulus for fetch_unit, checked against a
//            request-age model of the fetch timeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] pc_out;
  logic [15:0] link_pc;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] fetch_count;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_rdata   (mem_rdata),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_out      (pc_out),
    .link_pc     (link_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_count (fetch_count)
  );

  // Memory contents as a pure function of the address.
  function automatic logic [15:0] memf(input logic [15:0] a);
    logic [31:0] h;
    if (a == 16'h0000) return 16'h5105;
    if (a == 16'h0001) return 16'h0152;
    h = {16'h0000, a} * 32'h0000_9E37;
    return h[15:0] ^ 16'hA5C3;
  endfunction

  // Synchronous RAM; garbage when not read so a mistimed capture is visible.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= memf(mem_addr);
    else        mem_rdata <= 16'hDEAD;
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int req_cyc = 0;         // cycle in which the current request was issued
  logic [15:0] m_fetch;    // address of the current request
  logic [15:0] m_instr;
  logic [15:0] m_pc_out;
  logic [15:0] m_count;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int age();
    return cyc - req_cyc;
  endfunction

  // A request lives for one REQ cycle, one read cycle, then holds until taken.
  task automatic check_all();
    int a;
    a = age();
    check("mem_rd",      16'(mem_rd),      16'(a == 0));
    check("mem_addr",    mem_addr,         (a >= 2) ? m_fetch + 16'd1 : m_fetch);
    check("instr_valid", 16'(instr_valid), 16'(a >= 2));
    check("instr_out",   instr_out,        m_instr);
    check("pc_out",      pc_out,           m_pc_out);
    check("link_pc",     link_pc,          m_pc_out + 16'd1);
    check("fetch_count", fetch_count,      m_count);
  endtask

  task automatic step();
    int a;
    @(posedge clk);
    #1;
    if (reset) begin
      m_fetch  = 16'h0000;
      m_instr  = 16'h0000;
      m_pc_out = 16'h0000;
      m_count  = 16'h0000;
      req_cyc  = cyc + 1;
    end else begin
      a = age();
      if (a >= 2 && instr_ready) m_count = m_count + 16'd1;
      if (redirect) begin
        m_fetch = redirect_pc;
        req_cyc = cyc + 1;
      end else if (a == 1) begin
        m_instr  = memf(m_fetch);
        m_pc_out = m_fetch;
      end else if (a >= 2 && instr_ready) begin
        m_fetch = m_fetch + 16'd1;
        req_cyc = cyc + 1;
      end
    end
    cyc++;
    check_all();
  endtask

  task automatic wait_age(input int want, input bit at_least);
    int n;
    n = 0;
    while (at_least ? (age() < want) : (age() != want)) begin
      if (n == 10) begin
        checks++;
        errors++;
        $error("FAIL wait_age: got age %0d expected %0d", age(), want);
        return;
      end
      step();
      n++;
    end
  endtask

  initial begin
    reset       = 1'b1;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    m_fetch = 0; m_instr = 0; m_pc_out = 0; m_count = 0;
    step();
    step();
    reset = 1'b0;

    // Reset and first fetch with the consumer always ready.
    instr_ready = 1'b1;
    repeat (8) step();

    // Backpressure for five cycles after valid rises.
    instr_ready = 1'b0;
    wait_age(2, 1'b1);
    repeat (5) step();
    instr_ready = 1'b1;
    repeat (3) step();

    // Redirect during the read cycle.
    wait_age(1, 1'b0);
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    repeat (4) step();

    // Redirect and ready together while valid.
    instr_ready = 1'b0;
    wait_age(2, 1'b1);
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    step();
    redirect = 1'b0;
    repeat (4) step();

    // PC wrap past 16'hFFFF.
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    step();
    redirect = 1'b0;
    repeat (6) step();

    // Asynchronous reset between edges while valid.
    instr_ready = 1'b0;
    wait_age(2, 1'b1);
    #3 reset = 1'b1;
    #1;
    check("async instr_valid", 16'(instr_valid), 16'h0000);
    check("async mem_addr",    mem_addr,         16'h0000);
    check("async mem_rd",      16'(mem_rd),      16'h0001);
    check("async fetch_count", fetch_count,      16'h0000);
    check("async link_pc",     link_pc,          16'h0001);
    step();
    reset       = 1'b0;
    instr_ready = 1'b1;
    repeat (4) step();

    // Random traffic.
    repeat (600) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
